// File: rtl/riscv_definitions.sv
// Shared RV32I core definitions used by the integer register file.
package riscv_definitions;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned REG_COUNT  = 32;
    localparam int unsigned REG_ADDR   = $clog2(REG_COUNT);

    // Port-count ceilings for the multi-port register file.
    localparam int unsigned RF_MAX_RD  = 4;
    localparam int unsigned RF_MAX_WR  = 2;

    typedef logic [REG_ADDR-1:0]   reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared on writeback, x0 never busy.
module regfile_scoreboard #(
    parameter int unsigned NREGS  = 32,
    parameter int unsigned ADDR_W = $clog2(NREGS),
    parameter int unsigned NUM_WR = 1,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clk_en,
    input  logic [NUM_WR-1:0]        i_wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
    input  logic                     i_iss_en,
    input  logic [ADDR_W-1:0]        i_iss_addr,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD-1:0]        o_rd_busy,
    output logic [NREGS-1:0]         o_busy_vec
);

    logic [NREGS-1:0] busy_q, busy_d;

    // Next busy vector: writebacks clear first, then an issue sets so a new producer wins.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < int'(NUM_WR); j++) begin
            if (i_wr_en[j] && (i_wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
                busy_d[i_wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (i_iss_en && (i_iss_addr != '0)) begin
            busy_d[i_iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy state, frozen while the clock enable is low.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= '0;
        end else if (i_clk_en) begin
            busy_q <= busy_d;
        end
    end

    // Per-read-port busy lookup; bit 0 is held at zero so x0 reads as not busy.
    always_comb begin
        o_rd_busy = '0;
        for (int k = 0; k < int'(NUM_RD); k++) begin
            o_rd_busy[k] = busy_q[i_rd_addr[k*ADDR_W +: ADDR_W]];
        end
    end

    assign o_busy_vec = busy_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with optional write-to-read bypass and busy scoreboard.
module register_file_mp
    import riscv_definitions::*;
#(
    parameter int unsigned DATA_W = DATA_WIDTH,
    parameter int unsigned NREGS  = REG_COUNT,
    parameter int unsigned ADDR_W = $clog2(NREGS),
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 1,
    parameter int unsigned BYPASS = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clk_en,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic [NUM_RD-1:0]        o_rd_busy,
    input  logic [NUM_WR-1:0]        i_wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
    input  logic                     i_iss_en,
    input  logic [ADDR_W-1:0]        i_iss_addr,
    output logic [NREGS-1:0]         o_busy_vec
);

    if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
        $error("register_file_mp: NREGS must be a power of two >= 2");
    end
    if (ADDR_W != $clog2(NREGS)) begin : g_bad_addr_w
        $error("register_file_mp: ADDR_W must equal clog2(NREGS)");
    end
    if (NUM_RD < 1 || NUM_RD > RF_MAX_RD) begin : g_bad_num_rd
        $error("register_file_mp: NUM_RD out of range");
    end
    if (NUM_WR < 1 || NUM_WR > RF_MAX_WR) begin : g_bad_num_wr
        $error("register_file_mp: NUM_WR out of range");
    end
    if (BYPASS > 1) begin : g_bad_bypass
        $error("register_file_mp: BYPASS must be 0 or 1");
    end

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NUM_RD-1:0] byp_hit;
    logic [NUM_RD-1:0] sb_busy;

    // Write merge: later ports override earlier ones on the same address; x0 never written.
    always_comb begin
        for (int r = 0; r < int'(NREGS); r++) begin
            regs_d[r] = regs_q[r];
        end
        for (int r = 1; r < int'(NREGS); r++) begin
            for (int j = 0; j < int'(NUM_WR); j++) begin
                if (i_wr_en[j] && (i_wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    regs_d[r] = i_wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Register storage, frozen while the clock enable is low.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < int'(NREGS); r++) begin
                regs_q[r] <= '0;
            end
        end else if (i_clk_en) begin
            regs_q <= regs_d;
        end
    end

    // Combinational read ports; forwarding only when the write would actually land.
    always_comb begin
        o_rd_data = '0;
        byp_hit   = '0;
        for (int k = 0; k < int'(NUM_RD); k++) begin
            if (i_rd_addr[k*ADDR_W +: ADDR_W] != '0) begin
                o_rd_data[k*DATA_W +: DATA_W] = regs_q[i_rd_addr[k*ADDR_W +: ADDR_W]];
                if (BYPASS != 0 && i_clk_en && i_rst_n) begin
                    for (int j = 0; j < int'(NUM_WR); j++) begin
                        if (i_wr_en[j] &&
                            (i_wr_addr[j*ADDR_W +: ADDR_W] == i_rd_addr[k*ADDR_W +: ADDR_W])) begin
                            o_rd_data[k*DATA_W +: DATA_W] = i_wr_data[j*DATA_W +: DATA_W];
                            byp_hit[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clk_en   (i_clk_en),
        .i_wr_en    (i_wr_en),
        .i_wr_addr  (i_wr_addr),
        .i_iss_en   (i_iss_en),
        .i_iss_addr (i_iss_addr),
        .i_rd_addr  (i_rd_addr),
        .o_rd_busy  (sb_busy),
        .o_busy_vec (o_busy_vec)
    );

    // A forwarded value is the completed result, so it is never reported busy.
    assign o_rd_busy = sb_busy & ~byp_hit;

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a bypassing and a non-bypassing instance share stimulus.
module tb_register_file_mp;
    import riscv_definitions::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;

    logic [63:0] rd_data0, rd_data1;
    logic [1:0]  rd_busy0, rd_busy1;
    logic [31:0] busy_vec0, busy_vec1;

    always #5 clk = ~clk;

    register_file_mp #(.NUM_RD(2), .NUM_WR(2), .BYPASS(1)) u_dut_byp (
        .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en),
        .i_rd_addr(rd_addr), .o_rd_data(rd_data0), .o_rd_busy(rd_busy0),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_iss_en(iss_en), .i_iss_addr(iss_addr), .o_busy_vec(busy_vec0)
    );

    register_file_mp #(.NUM_RD(2), .NUM_WR(2), .BYPASS(0)) u_dut_nobyp (
        .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en),
        .i_rd_addr(rd_addr), .o_rd_data(rd_data1), .o_rd_busy(rd_busy1),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_iss_en(iss_en), .i_iss_addr(iss_addr), .o_busy_vec(busy_vec1)
    );

    // Reference model state.
    reg_data_t   mem_m [32];
    logic [31:0] busy_m;

    typedef struct {
        string       tag;
        int          dut;
        int          kind;  // 0 data, 1 port busy, 2 busy vector
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int d, input int kind, input int k);
        logic [31:0] v;
        case (kind)
            0:       v = (d == 0) ? rd_data0[k*32 +: 32] : rd_data1[k*32 +: 32];
            1:       v = {31'b0, (d == 0) ? rd_busy0[k] : rd_busy1[k]};
            default: v = (d == 0) ? busy_vec0 : busy_vec1;
        endcase
        return v;
    endfunction

    // Expected {busy, data} for read port k given current inputs and model state.
    function automatic logic [32:0] exp_read(input int k, input bit byp);
        logic [4:0]  a;
        logic [31:0] v;
        logic        b;
        a = rd_addr[k*5 +: 5];
        if (!rst_n || a == 5'd0) return 33'd0;
        v = mem_m[a];
        b = busy_m[a];
        if (byp && clk_en) begin
            for (int j = 0; j < 2; j++) begin
                if (wr_en[j] && wr_addr[j*5 +: 5] == a) begin
                    v = wr_data[j*32 +: 32];
                    b = 1'b0;
                end
            end
        end
        return {b, v};
    endfunction

    task automatic push_expect(input string tag);
        exp_t        e;
        logic [32:0] r;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2; k++) begin
                r      = exp_read(k, d == 0);
                e.dut  = d;
                e.port = k;
                e.tag  = $sformatf("%s.d%0d.rd%0d.data", tag, d, k);
                e.kind = 0;
                e.exp  = r[31:0];
                sb_q.push_back(e);
                e.tag  = $sformatf("%s.d%0d.rd%0d.busy", tag, d, k);
                e.kind = 1;
                e.exp  = {31'b0, r[32]};
                sb_q.push_back(e);
            end
            e.tag  = $sformatf("%s.d%0d.busy_vec", tag, d);
            e.kind = 2;
            e.port = 0;
            e.exp  = rst_n ? busy_m : 32'd0;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, observe(e.dut, e.kind, e.port), e.exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) mem_m[r] = '0;
        busy_m = '0;
    endtask

    task automatic model_step();
        logic [4:0] a;
        if (!rst_n || !clk_en) return;
        for (int j = 0; j < 2; j++) begin
            a = wr_addr[j*5 +: 5];
            if (wr_en[j] && a != 5'd0) begin
                mem_m[a]  = wr_data[j*32 +: 32];
                busy_m[a] = 1'b0;
            end
        end
        if (iss_en && iss_addr != 5'd0) busy_m[iss_addr] = 1'b1;
    endtask

    // Check current outputs, then advance one clock edge; returns at the next falling edge.
    task automatic step(input string tag);
        #1;
        push_expect(tag);
        drain();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en  = '0;
        iss_en = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic set_wr(input int j, input logic [4:0] a, input logic [31:0] d);
        wr_en[j]           = 1'b1;
        wr_addr[j*5 +: 5]  = a;
        wr_data[j*32 +: 32] = d;
    endtask

    task automatic issue(input logic [4:0] a);
        iss_en   = 1'b1;
        iss_addr = a;
    endtask

    initial begin
        rst_n   = 1'b0;
        clk_en  = 1'b1;
        wr_addr = '0;
        wr_data = '0;
        iss_addr = '0;
        idle();
        model_reset();

        // In reset, even an attempted write/issue must not show anywhere.
        set_rd(5'd0, 5'd5);
        set_wr(0, 5'd5, 32'h1111_2222);
        issue(5'd5);
        step("in_reset");
        idle();
        rst_n = 1'b1;

        step("rd_x0_x5");
        set_rd(5'd31, 5'd31);
        step("rd_x31");

        // x0 is hardwired zero.
        set_rd(5'd0, 5'd0);
        set_wr(0, 5'd0, 32'hDEAD_BEEF);
        step("wr_x0");
        idle();
        step("rd_x0");

        // Same-cycle forward vs. stored value.
        set_rd(5'd7, 5'd0);
        set_wr(0, 5'd7, 32'h1234_5678);
        step("wr_x7");
        idle();
        set_rd(5'd7, 5'd7);
        step("rd_x7");

        // Two writers to one register: higher-index port wins.
        set_rd(5'd9, 5'd9);
        set_wr(0, 5'd9, 32'hAAAA_0000);
        set_wr(1, 5'd9, 32'h5555_FFFF);
        step("dual_wr_x9");
        idle();
        step("rd_x9");

        // Scoreboard set, clear, and set-wins-over-clear.
        set_rd(5'd3, 5'd3);
        issue(5'd3);
        step("iss_x3");
        idle();
        step("busy_x3");
        set_wr(0, 5'd3, 32'h0000_0001);
        step("wr_x3");
        idle();
        step("clr_x3");
        issue(5'd3);
        set_wr(1, 5'd3, 32'h0000_0002);
        step("iss_wr_x3");
        idle();
        step("keep_x3");
        issue(5'd3);
        step("reiss_x3");
        idle();

        // Issue to x0 is ignored.
        set_rd(5'd0, 5'd3);
        issue(5'd0);
        step("iss_x0");
        idle();
        step("rd_after_iss_x0");

        // Clock enable low freezes everything and suppresses forwarding.
        set_rd(5'd4, 5'd4);
        clk_en = 1'b0;
        set_wr(0, 5'd4, 32'hFFFF_FFFF);
        issue(5'd4);
        step("gated_x4");
        step("gated_x4_hold");
        clk_en = 1'b1;
        step("en_x4");
        idle();
        step("rd_x4");

        // Asynchronous reset mid-cycle.
        set_rd(5'd10, 5'd11);
        set_wr(0, 5'd10, 32'h0000_CAFE);
        issue(5'd11);
        step("wr_x10_iss_x11");
        idle();
        #1;
        push_expect("pre_rst");
        drain();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        push_expect("async_rst");
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Multi-port, parametrised register bank for the RV32I core: the next-generation integer register file for dual-issue and wide-writeback pipeline variants.
- Provides NUM_RD asynchronous read ports and NUM_WR synchronous write ports.
- Adds optional write-to-read bypass and a per-register busy scoreboard, which sets on issue and clears on writeback.
- Sits between decode/issue (reads, busy query, issue-set) and writeback (writes, busy clear); x0 remains hardwired zero.

Parameters:
- DATA_W, default DATA_WIDTH (32): register width in bits.
- NREGS, default REG_COUNT (32): number of registers; must be a power of two, at least 2.
- ADDR_W, default $clog2(NREGS): register address width.
- NUM_RD, default 2: number of read ports, 1..4.
- NUM_WR, default 1: number of write ports, 1..2.
- BYPASS, default 1: 1 = same-cycle write data forwarded to matching reads; 0 = reads return the stored value.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous reset, active low.
- i_clk_en  in  1  clock enable; gates all state updates.
- i_rd_addr  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- o_rd_data  out  NUM_RD*DATA_W  read data, packed the same way.
- o_rd_busy  out  NUM_RD  busy flag of the register addressed by each read port.
- i_wr_en  in  NUM_WR  write enables.
- i_wr_addr  in  NUM_WR*ADDR_W  write addresses.
- i_wr_data  in  NUM_WR*DATA_W  write data.
- i_iss_en  in  1  issue strobe: mark the destination register pending.
- i_iss_addr  in  ADDR_W  destination register being issued.
- o_busy_vec  out  NREGS  full scoreboard; bit 0 is always 0.

Behaviour:
- Clock and reset: one clock, i_clk; reset i_rst_n is asynchronous, active-low.
  - Reset clears all registers to 0 and all busy bits to 0.
  - Consequently o_rd_data = 0, o_rd_busy = 0 and o_busy_vec = 0 while in reset.
- Reads are combinational, with zero latency:
  - Address 0 returns 0 with busy = 0, regardless of writes or bypass.
  - BYPASS=1: if any write port j has i_wr_en[j] high and a matching nonzero address, the read returns that port's i_wr_data in the same cycle and busy reads 0. The forward is suppressed when i_clk_en = 0.
  - BYPASS=0: reads return the stored value; the new value is visible the cycle after the write edge.
- Writes take effect on the rising edge when i_clk_en && i_wr_en[j] && address != 0.
  - Writes to x0 are dropped.
  - Two ports writing the same address in one cycle: the highest-index port wins, for both the stored value and the bypass selection.
- Scoreboard, evaluated at the rising edge when i_clk_en = 1:
  - An accepted write to register r clears busy[r].
  - i_iss_en with i_iss_addr = r (r != 0) sets busy[r].
  - Issue and write to the same r in the same cycle: set wins, so busy stays 1 (new producer issued).
  - i_iss_en to x0 is ignored.
  - Issue to a register that is already busy: it stays busy (no counting, no error).
  - A write to a register that is not busy is legal; the data is stored and the busy bit stays 0.
- i_clk_en = 0 freezes all state; reads still return stored values.
- Reset mid-operation: asynchronous clear, takes effect immediately and overrides any write or issue in that cycle.
- Out-of-range parameters are rejected by elaboration-time assertions.

Decomposition:
- riscv_definitions gains:
  - RF_MAX_RD = 4 and RF_MAX_WR = 2.
  - Typedef reg_addr_t = logic [REG_ADDR-1:0].
  - Typedef reg_data_t = logic [DATA_WIDTH-1:0].
- One natural sub-module: regfile_scoreboard (NREGS, ADDR_W, NUM_WR). It holds the busy vector, the set/clear priority logic and per-port busy lookup. Data storage, write arbitration and bypass muxes stay in register_file_mp.

Test Plan:
- Reset, then read ports 0..NUM_RD-1 at x0, x5, x31 -> all data 0 and all busy 0; write x0 = 0xDEADBEEF, then read x0 -> 0.
- BYPASS=1: write x7 = 0x12345678 and read x7 in the same cycle -> o_rd_data = 0x12345678 immediately. BYPASS=0: same cycle returns old value 0; next cycle returns 0x12345678.
- NUM_WR=2: port0 writes x9 = 0xAAAA0000 and port1 writes x9 = 0x5555FFFF in the same cycle -> stored value and bypassed value are both 0x5555FFFF.
- Issue x3 -> next cycle o_busy_vec[3] = 1 and o_rd_busy = 1 for a port reading x3. Write x3 = 0x1 -> busy cleared the next cycle. Issue x3 together with a write to x3 -> busy remains 1.
- i_clk_en = 0 with write x4 = 0xFFFF_FFFF and issue x4 -> x4 stays 0 and busy[4] stays 0. Raise i_clk_en -> both update.
- Write x10 = 0xCAFE and issue x11, then assert i_rst_n = 0 mid-cycle -> x10 reads 0 and o_busy_vec = 0 immediately, without waiting for a clock edge.
